// File: rtl/pwm_reg_controller.sv
// SPI-fed register sequencer for the PWM channels: shadow writes per frame, atomic per-channel
// commit at period boundaries. Define PWM_READBACK_EN to drive active bytes out on TXData.
module pwm_reg_controller #(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 8
) (
    input  logic                 CLK,
    input  logic                 _RST,
    input  logic                 _CS,
    input  logic                 RXValid,
    input  logic [7:0]           RXData,
    input  logic [NUM_CH-1:0]    PeriodEnd,
    output logic [16*NUM_CH-1:0] SwitchValues,
    output logic [16*NUM_CH-1:0] CountValues,
    output logic [16*NUM_CH-1:0] Prescalers,
    output logic [NUM_CH-1:0]    ChEnable,
    output logic                 AddrErr,
    output logic [7:0]           TXData
);
    localparam int REG_N = 6 * NUM_CH;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(REG_N - 1);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, ERR} state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        shadow [REG_N];
    logic [7:0]        active [REG_N];
    logic [NUM_CH-1:0] dirty;
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] hit_ch;
    logic [NUM_CH-1:0] commit;
    logic              closing;
    logic              addr_ok;
    logic              data_wr;

    assign addr_ok = ({1'b0, RXData} < 9'(REG_N));
    assign closing = _CS && (state != IDLE);
    assign data_wr = (state == DATA) && RXValid;
    // Commits only on a settled idle bus; the frame-closing cycle is excluded because state is not yet IDLE.
    assign commit  = (state == IDLE && _CS) ? (pending & PeriodEnd) : '0;

    always_comb begin
        state_next = state;
        if (_CS) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    state_next = ADDR;
                ADDR:    if (RXValid) state_next = addr_ok ? DATA : ERR;
                default: state_next = state;
            endcase
        end
    end

    always_comb begin
        hit_ch = '0;
        for (int i = 0; i < REG_N; i++) begin
            if (addr == ADDR_W'(i)) hit_ch[i / 6] = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge _RST) begin
        if (!_RST) begin
            state    <= IDLE;
            addr     <= '0;
            dirty    <= '0;
            pending  <= '0;
            ChEnable <= '0;
            AddrErr  <= 1'b0;
            for (int i = 0; i < REG_N; i++) begin
                shadow[i] <= 8'h00;
                active[i] <= 8'h00;
            end
        end else begin
            state <= state_next;
            if (state == ADDR && RXValid) begin
                addr    <= ADDR_W'(RXData);
                AddrErr <= !addr_ok;
            end
            if (data_wr) begin
                addr <= (addr == LAST_ADDR) ? '0 : addr + 1'b1;
                for (int i = 0; i < REG_N; i++) begin
                    if (addr == ADDR_W'(i)) shadow[i] <= RXData;
                end
            end
            // A byte landing on the closing edge still joins this frame's pending set.
            if (closing) begin
                pending <= (pending & ~commit) | dirty | (data_wr ? hit_ch : '0);
                dirty   <= '0;
            end else begin
                pending <= pending & ~commit;
                if (data_wr) dirty <= dirty | hit_ch;
            end
            for (int n = 0; n < NUM_CH; n++) begin
                if (commit[n]) begin
                    ChEnable[n] <= 1'b1;
                    for (int b = 0; b < 6; b++) begin
                        active[6*n+b] <= shadow[6*n+b];
                    end
                end
            end
        end
    end

    for (genvar n = 0; n < NUM_CH; n++) begin : g_pack
        assign SwitchValues[16*n +: 16] = {active[6*n],   active[6*n+1]};
        assign CountValues[16*n +: 16]  = {active[6*n+2], active[6*n+3]};
        assign Prescalers[16*n +: 16]   = {active[6*n+4], active[6*n+5]};
    end

`ifdef PWM_READBACK_EN
    always_comb begin
        TXData = 8'h00;
        if (state == DATA) begin
            for (int i = 0; i < REG_N; i++) begin
                if (addr == ADDR_W'(i)) TXData = active[i];
            end
        end
    end
`else
    assign TXData = 8'h00;
`endif

endmodule

// File: tb/tb_pwm_reg_controller.sv
// Scoreboard bench for pwm_reg_controller: a byte/frame-level register-map model predicts
// the active outputs and TXData; a negedge monitor pops and compares.
module tb_pwm_reg_controller;
    localparam int NUM_CH = 4;
    localparam int REG_N  = 6 * NUM_CH;
    localparam int W      = 48 * NUM_CH + NUM_CH + 1;
    localparam int PH_IDLE = 0;
    localparam int PH_ADDR = 1;
    localparam int PH_DATA = 2;
    localparam int PH_ERR  = 3;
`ifdef PWM_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 cs_n;
    logic                 rx_valid;
    logic [7:0]           rx_data;
    logic [NUM_CH-1:0]    pe;
    logic [16*NUM_CH-1:0] sw_vals;
    logic [16*NUM_CH-1:0] cnt_vals;
    logic [16*NUM_CH-1:0] pre_vals;
    logic [NUM_CH-1:0]    ch_en;
    logic                 addr_err;
    logic [7:0]           tx_data;

    pwm_reg_controller #(.NUM_CH(NUM_CH), .ADDR_W(8)) dut (
        .CLK(clk), ._RST(rst_n), ._CS(cs_n), .RXValid(rx_valid), .RXData(rx_data),
        .PeriodEnd(pe), .SwitchValues(sw_vals), .CountValues(cnt_vals),
        .Prescalers(pre_vals), .ChEnable(ch_en), .AddrErr(addr_err), .TXData(tx_data)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [7:0]        m_shadow [REG_N];
    logic [7:0]        m_active [REG_N];
    logic [NUM_CH-1:0] m_dirty, m_pending, m_en;
    logic              m_err;
    int                m_phase, m_addr;

    function automatic void model_reset();
        for (int i = 0; i < REG_N; i++) begin
            m_shadow[i] = 8'h00;
            m_active[i] = 8'h00;
        end
        m_dirty = '0; m_pending = '0; m_en = '0; m_err = 1'b0;
        m_phase = PH_IDLE; m_addr = 0;
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        if (m_phase == PH_ADDR) begin
            m_addr = int'(b);
            m_err  = (m_addr >= REG_N);
            m_phase = m_err ? PH_ERR : PH_DATA;
        end else if (m_phase == PH_DATA) begin
            m_shadow[m_addr] = b;
            m_dirty[m_addr / 6] = 1'b1;
            m_addr = (m_addr + 1) % REG_N;
        end
    endfunction

    function automatic void model_close();
        m_pending = m_pending | m_dirty;
        m_dirty = '0;
        m_phase = PH_IDLE;
    endfunction

    function automatic void model_commit(input logic [NUM_CH-1:0] mask);
        for (int n = 0; n < NUM_CH; n++) begin
            if (m_pending[n] && mask[n]) begin
                for (int b = 0; b < 6; b++) m_active[6*n+b] = m_shadow[6*n+b];
                m_pending[n] = 1'b0;
                m_en[n] = 1'b1;
            end
        end
    endfunction

    function automatic logic [7:0] model_tx();
        return (RB && m_phase == PH_DATA) ? m_active[m_addr] : 8'h00;
    endfunction

    function automatic logic [W-1:0] model_snap();
        logic [16*NUM_CH-1:0] sw, cnt, pre;
        for (int n = 0; n < NUM_CH; n++) begin
            sw[16*n +: 16]  = {m_active[6*n],   m_active[6*n+1]};
            cnt[16*n +: 16] = {m_active[6*n+2], m_active[6*n+3]};
            pre[16*n +: 16] = {m_active[6*n+4], m_active[6*n+5]};
        end
        return {sw, cnt, pre, m_en, m_err};
    endfunction

    // ---------------- scoreboard / monitor ----------------
    logic [W-1:0] exp_q[$];
    string        name_q[$];
    logic [7:0]   tx_q[$];
    logic         chk_stb = 1'b0;
    int           check_cnt = 0;
    int           pass_cnt = 0;

    always @(negedge clk) begin
        logic [W-1:0] e, act;
        logic [7:0]   te;
        string        nm;
        if (chk_stb) begin
            check_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL scoreboard: check strobe with empty expected queue");
            end else begin
                e = exp_q.pop_front();
                nm = name_q.pop_front();
                act = {sw_vals, cnt_vals, pre_vals, ch_en, addr_err};
                if (act === e) pass_cnt++;
                else $display("FAIL %s: got %h required %h", nm, act, e);
            end
        end
        if (rx_valid) begin
            check_cnt++;
            if (tx_q.size() == 0) begin
                $display("FAIL txdata: byte slot with empty expected queue");
            end else begin
                te = tx_q.pop_front();
                if (tx_data === te) pass_cnt++;
                else $display("FAIL txdata: got %h required %h", tx_data, te);
            end
        end
    end

    // ---------------- driver tasks ----------------
    logic [7:0] fb[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name);
        exp_q.push_back(model_snap());
        name_q.push_back(name);
        chk_stb = 1'b1;
        @(negedge clk);
        #1;
        chk_stb = 1'b0;
        tick();
    endtask

    task automatic pulse_pe(input logic [NUM_CH-1:0] mask);
        pe = mask;
        tick();
        pe = '0;
        model_commit(mask);
    endtask

    // Sends fb as one frame; optional PeriodEnd mid-frame and on the closing edge,
    // optionally with the last byte arriving on the same edge that _CS rises.
    task automatic run_frame(input logic [NUM_CH-1:0] mid_pe, input logic [NUM_CH-1:0] close_pe,
                             input bit join_last);
        bit joined;
        joined = join_last && (fb.size() >= 2);
        cs_n = 1'b0;
        tick();
        tick();
        m_phase = PH_ADDR;
        for (int i = 0; i < fb.size(); i++) begin
            if (i == 1 && mid_pe != '0) begin
                pe = mid_pe;
                tick();
                pe = '0;
            end
            tx_q.push_back(model_tx());
            rx_valid = 1'b1;
            rx_data = fb[i];
            if (joined && i == fb.size() - 1) begin
                cs_n = 1'b1;
                pe = close_pe;
            end
            tick();
            rx_valid = 1'b0;
            pe = '0;
            model_byte(fb[i]);
            if (!(joined && i == fb.size() - 1)) tick();
        end
        if (!joined) begin
            cs_n = 1'b1;
            pe = close_pe;
            tick();
            pe = '0;
        end
        model_close();
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; cs_n = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; pe = '0;
        model_reset();
        tick();
        tick();
        check("reset_state");
        rst_n = 1'b1;
        tick();

        fb = '{8'd0, 8'h02, 8'h40, 8'h04, 8'h80, 8'h00, 8'h04};
        run_frame('0, '0, 1'b0);
        check("ch0_before_pe");
        pulse_pe(4'b0001);
        check("ch0_commit");

        fb = '{8'd4, 8'h00, 8'h05, 8'hAB, 8'hCD};
        run_frame('0, '0, 1'b0);
        pulse_pe(4'b0011);
        check("boundary_ch0_ch1");

        fb = '{8'd0, 8'h02, 8'h40, 8'h04};
        run_frame('0, '0, 1'b0);
        check("readback_frame");

        fb = '{8'd23, 8'h11, 8'h22};
        run_frame('0, '0, 1'b0);
        pulse_pe(4'b1001);
        check("wrap_ch3_ch0");

        fb = '{8'd24, 8'h55};
        run_frame('0, '0, 1'b0);
        check("addr_err_set");
        pulse_pe(4'b1111);
        check("addr_err_no_pending");
        fb = '{8'd6};
        run_frame('0, '0, 1'b0);
        check("addr_err_cleared");

        fb = '{8'd12, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        run_frame(4'b0100, '0, 1'b0);
        check("deferred_no_commit");
        pulse_pe(4'b0100);
        check("deferred_commit");

        fb = '{8'd18, 8'hAA, 8'hBB};
        run_frame('0, '0, 1'b1);
        pulse_pe(4'b1000);
        check("byte_on_cs_rise");

        fb = '{8'd6, 8'h77};
        run_frame('0, 4'b0010, 1'b0);
        check("pe_on_idle_entry");
        pulse_pe(4'b0010);
        check("pe_after_idle_entry");

        fb.delete();
        run_frame('0, '0, 1'b0);
        pulse_pe(4'b1111);
        check("empty_frame");

        for (int k = 0; k < 40; k++) begin
            int len;
            len = $urandom_range(0, 9);
            fb.delete();
            if (len > 0) fb.push_back(8'($urandom_range(0, 27)));
            for (int j = 1; j < len; j++) fb.push_back(8'($urandom));
            run_frame(4'($urandom), 4'($urandom), 1'($urandom));
            check("rand_after_frame");
            pulse_pe(4'($urandom));
            check("rand_after_pe");
        end

        cs_n = 1'b0;
        tick();
        tick();
        m_phase = PH_ADDR;
        fb = '{8'd0, 8'h31, 8'h32, 8'h33};
        for (int i = 0; i < fb.size(); i++) begin
            tx_q.push_back(model_tx());
            rx_valid = 1'b1;
            rx_data = fb[i];
            tick();
            rx_valid = 1'b0;
            model_byte(fb[i]);
            tick();
        end
        rst_n = 1'b0;
        model_reset();
        check("reset_mid_frame");
        cs_n = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        pulse_pe(4'b1111);
        check("pe_after_reset");

        check_cnt++;
        if (exp_q.size() == 0 && tx_q.size() == 0) pass_cnt++;
        else $display("FAIL queues_drained: got %0d/%0d left required 0/0", exp_q.size(), tx_q.size());

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule
